// File: rtl/leaf_out_arbiter_pkg.sv
// Shared widths, packet field offsets and the route-table entry for the leaf output path.
package leaf_pkg;

   localparam int unsigned DEF_PAYLOAD_BITS   = 32;
   localparam int unsigned DEF_NUM_LEAF_BITS  = 5;
   localparam int unsigned DEF_NUM_PORT_BITS  = 4;
   localparam int unsigned DEF_NUM_ADDR_BITS  = 7;
   localparam int unsigned DEF_NUM_OUT_PORTS  = 6;
   localparam int unsigned DEF_FS_UPDATE_SIZE = 64;
   localparam int unsigned DEF_PACKET_BITS    = 1 + DEF_NUM_LEAF_BITS + DEF_NUM_PORT_BITS
                                                + DEF_NUM_ADDR_BITS + DEF_PAYLOAD_BITS;

   localparam int unsigned ADDR_LSB = DEF_PAYLOAD_BITS;
   localparam int unsigned PORT_LSB = ADDR_LSB + DEF_NUM_ADDR_BITS;
   localparam int unsigned LEAF_LSB = PORT_LSB + DEF_NUM_PORT_BITS;
   localparam int unsigned VLD_BIT  = LEAF_LSB + DEF_NUM_LEAF_BITS;

   typedef struct packed {
      logic                         configured;
      logic [DEF_NUM_LEAF_BITS-1:0] leaf;
      logic [DEF_NUM_PORT_BITS-1:0] dport;
   } route_t;

endpackage

// File: rtl/leaf_out_arbiter_if.sv
// User-stream and BFT-packet handshake bundle; master is the arbiter side.
interface leaf_out_arbiter_if
   import leaf_pkg::*;
#(
   parameter int unsigned NUM_OUT_PORTS = DEF_NUM_OUT_PORTS,
   parameter int unsigned PAYLOAD_BITS  = DEF_PAYLOAD_BITS,
   parameter int unsigned PACKET_BITS   = DEF_PACKET_BITS
);
   logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user;
   logic [NUM_OUT_PORTS-1:0]              vld_user;
   logic [NUM_OUT_PORTS-1:0]              ack_user;
   logic [PACKET_BITS-1:0]                pkt_out;
   logic                                  pkt_vld;
   logic                                  pkt_rdy;

   modport master (
      input  din_user, vld_user, pkt_rdy,
      output ack_user, pkt_out, pkt_vld
   );

   modport slave (
      output din_user, vld_user, pkt_rdy,
      input  ack_user, pkt_out, pkt_vld
   );
endinterface

// File: rtl/leaf_out_arbiter_rr.sv
// Combinational round-robin: first request found searching upward from last_grant_i+1, wrapping.
module rr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_grant_i,
   output logic [N-1:0]  grant_o
);
   logic          found;
   logic [IW-1:0] sel;

   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      sel     = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         sel = IW'((32'(last_grant_i) + k) % N);
         if (!found && req_i[sel]) begin
            grant_o[sel] = 1'b1;
            found        = 1'b1;
         end
      end
   end
endmodule

// File: rtl/leaf_out_arbiter.sv
// Round-robin merge of user output streams onto the BFT packet path with per-port route and credit.
module leaf_out_arbiter
   import leaf_pkg::*;
#(
   parameter int unsigned PACKET_BITS           = DEF_PACKET_BITS,
   parameter int unsigned PAYLOAD_BITS          = DEF_PAYLOAD_BITS,
   parameter int unsigned NUM_LEAF_BITS         = DEF_NUM_LEAF_BITS,
   parameter int unsigned NUM_PORT_BITS         = DEF_NUM_PORT_BITS,
   parameter int unsigned NUM_ADDR_BITS         = DEF_NUM_ADDR_BITS,
   parameter int unsigned NUM_OUT_PORTS         = DEF_NUM_OUT_PORTS,
   parameter int unsigned FREESPACE_UPDATE_SIZE = DEF_FS_UPDATE_SIZE
) (
   input  logic                     clk,
   input  logic                     reset,
   leaf_out_arbiter_if.master       bus,
   input  logic                     cfg_wr,
   input  logic [NUM_PORT_BITS-1:0] cfg_port,
   input  logic [NUM_LEAF_BITS-1:0] cfg_leaf,
   input  logic [NUM_PORT_BITS-1:0] cfg_dport,
   input  logic                     fs_vld,
   input  logic [NUM_PORT_BITS-1:0] fs_port
);
   localparam int unsigned IDX_W  = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
   localparam int unsigned CRED_W = NUM_ADDR_BITS + 1;
   localparam logic [CRED_W-1:0] CRED_MAX = {1'b1, {NUM_ADDR_BITS{1'b0}}};
   localparam logic [CRED_W:0]   FS_INC   = (CRED_W + 1)'(FREESPACE_UPDATE_SIZE);

   route_t                   route_q  [NUM_OUT_PORTS];
   route_t                   route_d  [NUM_OUT_PORTS];
   logic [CRED_W-1:0]        credit_q [NUM_OUT_PORTS];
   logic [CRED_W-1:0]        credit_d [NUM_OUT_PORTS];
   logic [NUM_ADDR_BITS-1:0] addr_q   [NUM_OUT_PORTS];
   logic [NUM_ADDR_BITS-1:0] addr_d   [NUM_OUT_PORTS];
   logic [IDX_W-1:0]         last_q, last_d;
   logic [PACKET_BITS-1:0]   pkt_q, pkt_d;
   logic                     pkt_vld_q, pkt_vld_d;

   logic                     out_free;
   logic [NUM_OUT_PORTS-1:0] req, grant;
   logic [CRED_W:0]          sum;

   always_comb begin
      out_free = !pkt_vld_q || bus.pkt_rdy;
      req      = '0;
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
         req[i] = bus.vld_user[i] && route_q[i].configured && (credit_q[i] != '0) && out_free;
      end
   end

   rr_arbiter #(.N(NUM_OUT_PORTS), .IW(IDX_W)) u_rr (
      .req_i        (req),
      .last_grant_i (last_q),
      .grant_o      (grant)
   );

   assign bus.ack_user = grant;
   assign bus.pkt_out  = pkt_q;
   assign bus.pkt_vld  = pkt_vld_q;

   always_comb begin
      route_d   = route_q;
      credit_d  = credit_q;
      addr_d    = addr_q;
      last_d    = last_q;
      pkt_d     = pkt_q;
      pkt_vld_d = pkt_vld_q;
      sum       = '0;
      if (out_free) pkt_vld_d = 1'b0;
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
         if (grant[i]) begin
            pkt_d     = {1'b1, route_q[i].leaf, route_q[i].dport, addr_q[i],
                         bus.din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
            pkt_vld_d = 1'b1;
            last_d    = IDX_W'(i);
            addr_d[i] = addr_q[i] + NUM_ADDR_BITS'(1);
         end
         // Update and grant net out before saturating, so a full counter still absorbs the decrement.
         sum = {1'b0, credit_q[i]}
             + ((fs_vld && fs_port == NUM_PORT_BITS'(i + 1) && route_q[i].configured) ? FS_INC : '0)
             - (CRED_W + 1)'(grant[i]);
         credit_d[i] = (sum > {1'b0, CRED_MAX}) ? CRED_MAX : sum[CRED_W-1:0];
         // Config overrides credit/addr, but the packet built above already used the old route.
         if (cfg_wr && cfg_port == NUM_PORT_BITS'(i + 1)) begin
            route_d[i].configured = 1'b1;
            route_d[i].leaf       = cfg_leaf;
            route_d[i].dport      = cfg_dport;
            credit_d[i]           = CRED_MAX;
            addr_d[i]             = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            route_q[i]  <= '0;
            credit_q[i] <= '0;
            addr_q[i]   <= '0;
         end
         last_q    <= '0;
         pkt_q     <= '0;
         pkt_vld_q <= 1'b0;
      end else begin
         route_q   <= route_d;
         credit_q  <= credit_d;
         addr_q    <= addr_d;
         last_q    <= last_d;
         pkt_q     <= pkt_d;
         pkt_vld_q <= pkt_vld_d;
      end
   end
endmodule

// File: doc/leaf_out_arbiter.md
Name: leaf_out_arbiter

Overview:
- Sits inside the leaf interface, between the user kernel's output streams (`din_leaf_user2interface_N` / vld / ack) and the single packet path toward the BFT.
- Shares the one-packet-per-cycle BFT output among NUM_OUT_PORTS requesters using round-robin arbitration.
- Stamps each granted word with its configured destination (leaf, port) and a per-port write address.
- Enforces per-port credit (receiver freespace) flow control. Credit returns arrive as freespace updates from the destination leaves.

Parameters:
- PACKET_BITS, 49, total packet width = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS
- PAYLOAD_BITS, 32, user data width
- NUM_LEAF_BITS, 5, destination leaf field width
- NUM_PORT_BITS, 4, destination port field width
- NUM_ADDR_BITS, 7, receiver BRAM address width; credit capacity = 2^NUM_ADDR_BITS
- NUM_OUT_PORTS, 6, number of user output streams (1..15)
- FREESPACE_UPDATE_SIZE, 64, credits added per freespace update

Ports:
- clk  in  1  interface clock
- reset  in  1  asynchronous, active-high reset
- din_user  in  NUM_OUT_PORTS*PAYLOAD_BITS  user payloads; port i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS]
- vld_user  in  NUM_OUT_PORTS  per-port data valid
- ack_user  out  NUM_OUT_PORTS  per-port accept; combinational, one-hot or zero
- cfg_wr  in  1  route config write strobe
- cfg_port  in  NUM_PORT_BITS  local output port being configured (1-based, matching _1.._N)
- cfg_leaf  in  NUM_LEAF_BITS  destination leaf
- cfg_dport  in  NUM_PORT_BITS  destination input port
- fs_vld  in  1  freespace update strobe
- fs_port  in  NUM_PORT_BITS  local output port that receives the credits (1-based)
- pkt_out  out  PACKET_BITS  {1'b1, leaf, dport, addr, payload}, MSB first
- pkt_vld  out  1  pkt_out valid
- pkt_rdy  in  1  BFT side accepts pkt_out this cycle

Behaviour:
- Reset values:
  - pkt_out = 0, pkt_vld = 0, ack_user = 0.
  - All ports unconfigured.
  - Credits = 0; addresses = 0; round-robin pointer = port 0.
- Output register:
  - Holds exactly one packet.
  - It is "free" when pkt_vld = 0 or pkt_rdy = 1.
  - While pkt_vld = 1 and pkt_rdy = 0, pkt_out is held stable.
- Eligibility: port i is eligible when vld_user[i], configured[i], credit[i] > 0, and the output register is free.
- Arbitration:
  - Round-robin over eligible ports, searching upward from the port after the last grant, with wrap-around.
  - At most one ack_user bit is set per cycle, asserted in the same cycle as eligibility.
  - A handshake occurs when vld_user[i] and ack_user[i] are both high.
- On grant of port i, at the next clock edge:
  - pkt_out = {1, leaf[i], dport[i], addr[i], din_user[i]}; pkt_vld = 1.
  - addr[i] increments modulo 2^NUM_ADDR_BITS (127 wraps to 0).
  - credit[i] decrements by 1.
  - The round-robin pointer moves to i.
  - Latency from vld to pkt_vld is 1 cycle.
- No grant while free: pkt_vld drops to 0 after pkt_rdy; pkt_out keeps its last value.
- Config write (cfg_wr with cfg_port in 1..NUM_OUT_PORTS):
  - Stores leaf/dport, sets configured, credit = 2^NUM_ADDR_BITS, addr = 0.
  - Out-of-range cfg_port is ignored.
  - Same-cycle grant of the same port: the grant uses the old route; config wins for credit and addr.
- Freespace update (fs_vld):
  - credit[fs_port] += FREESPACE_UPDATE_SIZE, saturating at 2^NUM_ADDR_BITS.
  - Ignored for an unconfigured or out-of-range port.
- Simultaneous update and grant on the same port: net = credit + FREESPACE_UPDATE_SIZE - 1, then saturate.
- Credit counters are NUM_ADDR_BITS+1 bits wide; a zero credit count blocks that port only.
- Reset mid-operation: an in-flight pkt_out is discarded immediately (async clear); the user side must re-send.

Decomposition:
- Shared package (leaf_pkg):
  - Field width constants and packet field offsets (VLD_BIT, LEAF_LSB, PORT_LSB, ADDR_LSB).
  - Typedef for the route entry {configured, leaf, dport}.
- One sub-module: rr_arbiter (parameter N; inputs req[N], last_grant; output grant one-hot). It is combinational priority rotation and is reused by the input side.

Test Plan:
- Single port: configure port 1 to leaf 3 / dport 2, drive 0xDEADBEEF with pkt_rdy = 1 → next cycle pkt_out = {1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}; second word carries addr 1.
- Round-robin: ports 1, 2 and 4 configured and continuously valid, pkt_rdy = 1 → grants 1, 2, 4, 1, 2, 4; no port starves.
- Credit exhaustion: 128 words on port 1 with no freespace update → word 129 gets no ack. One fs_vld for port 1 → exactly 64 more words accepted. Addr wraps 127 → 0.
- Backpressure: pkt_rdy = 0 for 5 cycles with port 1 valid → pkt_out stable, ack_user = 0, credit unchanged; accepts resume on the cycle pkt_rdy returns to 1.
- Saturation and simultaneous events: with credit 100, fs_vld together with a grant on the same port → credit 128, not 163. Config write of the same port during a grant → credit 128, addr 0.
- Async reset mid-stream with pkt_vld = 1 → pkt_vld and ack_user go 0 immediately; after release, unconfigured ports get no ack.
